cpu_controller: RTL

- Eight-phase instruction-cycle sequencer for the lab CPU; sits directly upstream of the address mux and drives its `sel` input (PC vs IR operand address).
- Also drives memory read/write, IR/AC/PC load enables, PC increment, data-bus enable and halt.
- Outputs are decoded from the current phase plus the 3-bit opcode held in the instruction register.

---
 rtl/cpu_controller.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cpu_controller.sv
// Eight-phase instruction-cycle sequencer; control strobes decode from phase, opcode and zero.
// Optional CTRL_HALT_LATCH_EN: an HLT freezes the sequencer at OP_ADDR until rst_.
module cpu_controller #(
    parameter int OPCODE_W = 3
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                mem_rd,
    output logic                load_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                load_ac,
    output logic                load_pc,
    output logic                mem_wr,
    output logic                data_e
);

    localparam int NUM_PHASES = 8;
    localparam int PHASE_W    = $clog2(NUM_PHASES);

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SKZ = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_STO = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

    phase_t phase;
    phase_t phase_next;
    logic   halted;
    logic   alu_op;

    assign phase_next = phase_t'(phase + 1'b1);

`ifdef CTRL_HALT_LATCH_EN
    // The opcode only qualifies the halt latch, so an X opcode can at worst leave it clear.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase  <= INST_ADDR;
            halted <= 1'b0;
        end else if (halted) begin
            phase <= OP_ADDR;
        end else if (phase == OP_ADDR && opcode == OP_HLT) begin
            halted <= 1'b1;
            phase  <= OP_ADDR;
        end else begin
            phase <= phase_next;
        end
    end
`else
    assign halted = 1'b0;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase <= INST_ADDR;
        end else begin
            phase <= phase_next;
        end
    end
`endif

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

    always_comb begin
        sel     = 1'b0;
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        data_e  = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel    = 1'b1;
                    mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel     = 1'b1;
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: begin
                    mem_rd = alu_op;
                end
                ALU_OP: begin
                    mem_rd  = alu_op;
                    inc_pc  = (opcode == OP_SKZ) && zero;
                    load_pc = (opcode == OP_JMP);
                    data_e  = (opcode == OP_STO);
                end
                STORE: begin
                    mem_rd  = alu_op;
                    inc_pc  = (opcode == OP_JMP);
                    load_ac = alu_op;
                    load_pc = (opcode == OP_JMP);
                    mem_wr  = (opcode == OP_STO);
                    data_e  = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b1;
                end
            endcase
        end
    end

endmodule
